// File: rtl/rc4_prga_decrypt.sv
// RC4 PRGA decryption engine: walks S to produce keystream bytes and XORs them with the message ROM.
// Optional plaintext check (lowercase letters and space only) enabled by defining RC4_PLAINTEXT_CHECK_EN.
module rc4_prga_decrypt #(
    parameter int unsigned MSG_LEN = 32,
    parameter int unsigned MSG_AW  = $clog2(MSG_LEN),
    parameter int unsigned RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [7:0]        s_addr,
    output logic [7:0]        s_wdata,
    output logic              s_wren,
    input  logic [7:0]        s_rdata,
    output logic [MSG_AW-1:0] enc_addr,
    input  logic [7:0]        enc_rdata,
    output logic [MSG_AW-1:0] dec_addr,
    output logic [7:0]        dec_wdata,
    output logic              dec_wren,
    output logic              busy,
    output logic              done,
    output logic              key_bad
);

    typedef enum logic [3:0] {
        IDLE, INC_I, RD_SI, INC_J, RD_SJ, WR_J, WR_I, RD_F, WR_DEC, DONE
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d, f_q, f_d;
    logic [MSG_AW-1:0] k_q, k_d;
    logic [1:0]        rd_cnt_q, rd_cnt_d;
    logic              key_bad_q, key_bad_d;
    logic              rd_last, last_byte, pt_bad;
    logic [7:0]        pt_byte;

    assign rd_last   = (rd_cnt_q == 2'(RD_LAT - 1));
    assign last_byte = (k_q == MSG_AW'(MSG_LEN - 1));
    assign pt_byte   = f_q ^ enc_rdata;

`ifdef RC4_PLAINTEXT_CHECK_EN
    assign pt_bad = !(((pt_byte >= 8'h61) && (pt_byte <= 8'h7A)) || (pt_byte == 8'h20));
`else
    assign pt_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            i_q       <= 8'd0;
            j_q       <= 8'd0;
            si_q      <= 8'd0;
            sj_q      <= 8'd0;
            f_q       <= 8'd0;
            k_q       <= '0;
            rd_cnt_q  <= 2'd0;
            key_bad_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            si_q      <= si_d;
            sj_q      <= sj_d;
            f_q       <= f_d;
            k_q       <= k_d;
            rd_cnt_q  <= rd_cnt_d;
            key_bad_q <= key_bad_d;
        end
    end

    // Next-state and output decode; read states hold for RD_LAT cycles and capture on the last.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        si_d      = si_q;
        sj_d      = sj_q;
        f_d       = f_q;
        k_d       = k_q;
        rd_cnt_d  = 2'd0;
        key_bad_d = key_bad_q;
        s_addr    = 8'd0;
        s_wdata   = 8'd0;
        s_wren    = 1'b0;
        dec_wdata = 8'd0;
        dec_wren  = 1'b0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = INC_I;
                    i_d       = 8'd0;
                    j_d       = 8'd0;
                    si_d      = 8'd0;
                    sj_d      = 8'd0;
                    f_d       = 8'd0;
                    k_d       = '0;
                    key_bad_d = 1'b0;
                end
            end
            INC_I: begin
                i_d     = i_q + 8'd1;
                state_d = RD_SI;
            end
            RD_SI: begin
                s_addr = i_q;
                if (rd_last) begin
                    si_d    = s_rdata;
                    state_d = INC_J;
                end else begin
                    rd_cnt_d = rd_cnt_q + 2'd1;
                end
            end
            INC_J: begin
                j_d     = j_q + si_q;
                state_d = RD_SJ;
            end
            RD_SJ: begin
                s_addr = j_q;
                if (rd_last) begin
                    sj_d    = s_rdata;
                    state_d = WR_J;
                end else begin
                    rd_cnt_d = rd_cnt_q + 2'd1;
                end
            end
            WR_J: begin
                s_addr  = j_q;
                s_wdata = si_q;
                s_wren  = 1'b1;
                state_d = WR_I;
            end
            // When i==j this second write lands on the same entry and leaves sj there.
            WR_I: begin
                s_addr  = i_q;
                s_wdata = sj_q;
                s_wren  = 1'b1;
                state_d = RD_F;
            end
            RD_F: begin
                s_addr = si_q + sj_q;
                if (rd_last) begin
                    f_d     = s_rdata;
                    state_d = WR_DEC;
                end else begin
                    rd_cnt_d = rd_cnt_q + 2'd1;
                end
            end
            WR_DEC: begin
                dec_wdata = pt_byte;
                dec_wren  = 1'b1;
                if (pt_bad) begin
                    key_bad_d = 1'b1;
                    state_d   = DONE;
                end else if (last_byte) begin
                    state_d = DONE;
                end else begin
                    k_d     = k_q + MSG_AW'(1);
                    state_d = INC_I;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Strobes of the abort cycle still fire; the run then ends without further writes.
        if (abort && (state_q != IDLE) && (state_q != DONE)) begin
            state_d   = DONE;
            rd_cnt_d  = 2'd0;
            key_bad_d = 1'b1;
        end
    end

    assign enc_addr = k_q;
    assign dec_addr = k_q;
    assign busy     = (state_q != IDLE);
    assign key_bad  = key_bad_q;

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Directed bench for rc4_prga_decrypt: one RD_LAT=1/MSG_LEN=4 instance and one RD_LAT=3/MSG_LEN=2 instance.
module tb_rc4_prga_decrypt;

`ifdef RC4_PLAINTEXT_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    localparam int unsigned LEN_A = 4;
    localparam int unsigned AW_A  = 2;
    localparam int unsigned LEN_B = 2;
    localparam int unsigned AW_B  = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- instance A ----------------
    logic            start_a = 1'b0, abort_a = 1'b0;
    logic [7:0]      s_addr_a, s_wdata_a, s_rdata_a, enc_rdata_a, dec_wdata_a;
    logic            s_wren_a, dec_wren_a, busy_a, done_a, key_bad_a;
    logic [AW_A-1:0] enc_addr_a, dec_addr_a;
    logic [7:0]      sm_a [256];
    logic [7:0]      enc_a [LEN_A];
    logic [7:0]      dec_a [LEN_A];
    logic            init_a = 1'b0;
    int              swr_a = 0, dwr_a = 0;

    rc4_prga_decrypt #(.MSG_LEN(LEN_A), .MSG_AW(AW_A), .RD_LAT(1)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
        .s_addr(s_addr_a), .s_wdata(s_wdata_a), .s_wren(s_wren_a), .s_rdata(s_rdata_a),
        .enc_addr(enc_addr_a), .enc_rdata(enc_rdata_a),
        .dec_addr(dec_addr_a), .dec_wdata(dec_wdata_a), .dec_wren(dec_wren_a),
        .busy(busy_a), .done(done_a), .key_bad(key_bad_a)
    );

    assign s_rdata_a   = sm_a[s_addr_a];
    assign enc_rdata_a = enc_a[enc_addr_a];

    always @(posedge clk) begin
        if (init_a) begin
            for (int x = 0; x < 256; x++) sm_a[x] <= 8'(x);
            for (int x = 0; x < int'(LEN_A); x++) dec_a[x] <= 8'd0;
            swr_a <= 0;
            dwr_a <= 0;
        end else begin
            if (s_wren_a) begin
                sm_a[s_addr_a] <= s_wdata_a;
                swr_a <= swr_a + 1;
            end
            if (dec_wren_a) begin
                dec_a[dec_addr_a] <= dec_wdata_a;
                dwr_a <= dwr_a + 1;
            end
        end
    end

    // ---------------- instance B (3-cycle read latency) ----------------
    logic            start_b = 1'b0, abort_b = 1'b0;
    logic [7:0]      s_addr_b, s_wdata_b, s_rdata_b, enc_rdata_b, dec_wdata_b;
    logic            s_wren_b, dec_wren_b, busy_b, done_b, key_bad_b;
    logic [AW_B-1:0] enc_addr_b, dec_addr_b, ep1_b, ep2_b;
    logic [7:0]      ap1_b, ap2_b;
    logic [7:0]      sm_b [256];
    logic [7:0]      enc_b [LEN_B];
    logic [7:0]      dec_b [LEN_B];
    logic            init_b = 1'b0;

    rc4_prga_decrypt #(.MSG_LEN(LEN_B), .MSG_AW(AW_B), .RD_LAT(3)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .s_addr(s_addr_b), .s_wdata(s_wdata_b), .s_wren(s_wren_b), .s_rdata(s_rdata_b),
        .enc_addr(enc_addr_b), .enc_rdata(enc_rdata_b),
        .dec_addr(dec_addr_b), .dec_wdata(dec_wdata_b), .dec_wren(dec_wren_b),
        .busy(busy_b), .done(done_b), .key_bad(key_bad_b)
    );

    always @(posedge clk) begin
        ap1_b <= s_addr_b;
        ap2_b <= ap1_b;
        ep1_b <= enc_addr_b;
        ep2_b <= ep1_b;
    end
    assign s_rdata_b   = sm_b[ap2_b];
    assign enc_rdata_b = enc_b[ep2_b];

    always @(posedge clk) begin
        if (init_b) begin
            for (int x = 0; x < 256; x++) sm_b[x] <= 8'(x);
            for (int x = 0; x < int'(LEN_B); x++) dec_b[x] <= 8'd0;
        end else begin
            if (s_wren_b) sm_b[s_addr_b] <= s_wdata_b;
            if (dec_wren_b) dec_b[dec_addr_b] <= dec_wdata_b;
        end
    end

    // ---------------- helpers ----------------
    int s2_cap, s3_cap;

    task automatic load_a(input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3);
        enc_a[0] = e0; enc_a[1] = e1; enc_a[2] = e2; enc_a[3] = e3;
        @(negedge clk) init_a = 1'b1;
        @(negedge clk) init_a = 1'b0;
    endtask

    // Start at edge E0, then count cycles; optional abort/rst/start pokes at given cycles.
    task automatic run_a(input int abort_cyc, input int rst_cyc, input int poke_cyc,
                         output int done_cyc, output int kb1);
        done_cyc = -1;
        kb1      = -1;
        s2_cap   = -1;
        s3_cap   = -1;
        @(negedge clk) start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (n == 1) kb1 = int'(key_bad_a);
            if (n == 17) begin
                s2_cap = int'(sm_a[2]);
                s3_cap = int'(sm_a[3]);
            end
            if (done_a) begin
                done_cyc = n;
                break;
            end
            if (rst_cyc > 0 && n == rst_cyc + 1) break;
            abort_a = (n == abort_cyc);
            start_a = (n == poke_cyc);
            rst     = (n == rst_cyc);
        end
        abort_a = 1'b0;
        start_a = 1'b0;
    endtask

    int dc, kb;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy",    int'(busy_a),    0);
        check("rst_done",    int'(done_a),    0);
        check("rst_key_bad", int'(key_bad_a), 0);
        check("rst_s_wren",  int'(s_wren_a),  0);
        check("rst_s_addr",  int'(s_addr_a),  0);
        check("rst_dec_wren", int'(dec_wren_a), 0);
        rst = 1'b0;

        // Identity S, zero ciphertext: keystream 02 05 07 0d
        load_a(8'h00, 8'h00, 8'h00, 8'h00);
        run_a(0, 0, 0, dc, kb);
        check("z_done_cyc", dc, CHK ? 9 : 33);
        check("z_key_bad",  int'(key_bad_a), CHK ? 1 : 0);
        check("z_dec0",     int'(dec_a[0]), 8'h02);
        check("z_dec1",     int'(dec_a[1]), CHK ? 0 : 8'h05);
        check("z_dec2",     int'(dec_a[2]), CHK ? 0 : 8'h07);
        check("z_dec3",     int'(dec_a[3]), CHK ? 0 : 8'h0d);
        check("z_s2_byte1", s2_cap, CHK ? -1 : 3);
        check("z_s3_byte1", s3_cap, CHK ? -1 : 2);
        @(negedge clk);
        check("z_done_pulse", int'(done_a), 0);
        check("z_busy_idle",  int'(busy_a), 0);
        repeat (3) @(negedge clk);
        check("z_s_writes",   swr_a, CHK ? 2 : 8);
        check("z_dec_writes", dwr_a, CHK ? 1 : 4);
        check("z_key_bad_held", int'(key_bad_a), CHK ? 1 : 0);

        // Ciphertext decoding to "aa" then 07 0d
        load_a(8'h63, 8'h64, 8'h00, 8'h00);
        run_a(0, 0, 0, dc, kb);
        check("p_done_cyc", dc, CHK ? 25 : 33);
        check("p_key_bad",  int'(key_bad_a), CHK ? 1 : 0);
        check("p_kb_cleared", kb, 0);
        check("p_dec0", int'(dec_a[0]), 8'h61);
        check("p_dec1", int'(dec_a[1]), 8'h61);
        check("p_dec2", int'(dec_a[2]), 8'h07);
        check("p_dec3", int'(dec_a[3]), CHK ? 0 : 8'h0d);
        @(negedge clk);
        check("p_dec_writes", dwr_a, CHK ? 3 : 4);

        // Abort during RD_SJ of byte 1 (cycle 12)
        load_a(8'h63, 8'h64, 8'h00, 8'h00);
        run_a(12, 0, 0, dc, kb);
        check("a_done_cyc", dc, 13);
        check("a_key_bad",  int'(key_bad_a), 1);
        @(negedge clk);
        check("a_s_writes",   swr_a, 2);
        check("a_dec_writes", dwr_a, 1);
        check("a_busy_idle",  int'(busy_a), 0);
        load_a(8'h63, 8'h64, 8'h00, 8'h00);
        run_a(0, 0, 0, dc, kb);
        check("ar_kb_cleared", kb, 0);
        check("ar_done_cyc", dc, CHK ? 25 : 33);
        check("ar_dec0", int'(dec_a[0]), 8'h61);
        check("ar_dec1", int'(dec_a[1]), 8'h61);

        // Reset in WR_I of byte 0 (cycle 6), outputs sampled while rst is still high
        load_a(8'h63, 8'h64, 8'h00, 8'h00);
        run_a(0, 6, 0, dc, kb);
        check("r_busy",     int'(busy_a),     0);
        check("r_s_wren",   int'(s_wren_a),   0);
        check("r_s_addr",   int'(s_addr_a),   0);
        check("r_s_wdata",  int'(s_wdata_a),  0);
        check("r_dec_wren", int'(dec_wren_a), 0);
        check("r_done",     int'(done_a),     0);
        check("r_enc_addr", int'(enc_addr_a), 0);
        rst = 1'b0;
        load_a(8'h63, 8'h64, 8'h00, 8'h00);
        run_a(0, 0, 3, dc, kb);
        check("rp_done_cyc", dc, CHK ? 25 : 33);
        check("rp_dec0", int'(dec_a[0]), 8'h61);
        check("rp_dec1", int'(dec_a[1]), 8'h61);
        check("rp_dec2", int'(dec_a[2]), 8'h07);

        // RD_LAT=3 instance, two bytes, 14 cycles each
        enc_b[0] = 8'h63;
        enc_b[1] = 8'h64;
        @(negedge clk) init_b = 1'b1;
        @(negedge clk) init_b = 1'b0;
        start_b = 1'b1;
        @(posedge clk);
        #1 start_b = 1'b0;
        dc = -1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (done_b) begin
                dc = n;
                break;
            end
        end
        check("b_done_cyc", dc, 29);
        check("b_key_bad",  int'(key_bad_b), 0);
        check("b_dec0", int'(dec_b[0]), 8'h61);
        check("b_dec1", int'(dec_b[1]), 8'h61);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
